// File: rtl/loader_pkg.sv
// Shared types and default constants for the program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam int unsigned LOADER_MAX_WORDS = 23001;
    localparam logic [7:0]  LOADER_ACK_BYTE  = 8'hAA;
    localparam logic [7:0]  LOADER_NAK_BYTE  = 8'h55;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid fires
// combinationally in the cycle the 4th byte arrives.
module byte_word_assembler (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0] byte_idx_reg;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            byte_idx_reg <= 2'd0;
        end else if (clear) begin
            byte_idx_reg <= 2'd0;
        end else if (in_valid) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
        end
    end

    // Only the low three lanes are stored; the top lane is the live input byte.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or posedge rstn) begin
                if (rstn) begin
                    lane_reg <= 8'd0;
                end else if (in_valid && !clear && (byte_idx_reg == 2'(gi))) begin
                    lane_reg <= in_byte;
                end
            end

            assign word[8*gi+7:8*gi] = lane_reg;
        end
    endgenerate

    assign word[31:24] = in_byte;
    assign word_valid  = in_valid && !clear && (byte_idx_reg == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a header-prefixed word image into instruction memory and acknowledges it.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing 32-bit sum word.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = LOADER_MAX_WORDS,
    parameter logic [7:0]  ACK_BYTE  = LOADER_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE  = LOADER_NAK_BYTE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [31:0] pro_addr,
    output logic [31:0] pro_data,
    output logic        memwrite,
    output logic        load_done,
    output logic        load_error,
    output logic        tx_valid,
    output logic [7:0]  tx_data
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_t POST_DATA = CSUM;
`else
    localparam loader_state_t POST_DATA = DONE;
`endif

    loader_state_t state_reg, state_next;
    logic [31:0]   n_reg, n_next;
    logic [31:0]   word_idx_reg, word_idx_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0]   sum_reg, sum_next;
`endif

    logic [31:0] pro_addr_reg, pro_addr_next;
    logic [31:0] pro_data_reg, pro_data_next;
    logic        memwrite_reg, memwrite_next;
    logic        load_done_reg, load_done_next;
    logic        load_error_reg, load_error_next;
    logic        tx_valid_reg, tx_valid_next;
    logic [7:0]  tx_data_reg, tx_data_next;

    logic        word_valid;
    logic [31:0] word;
    logic        terminal;
    logic        enter_done;
    logic        enter_err;

    assign terminal = (state_reg == DONE) || (state_reg == ERR);

    byte_word_assembler u_assembler (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (terminal),
        .in_valid   (rx_valid),
        .in_byte    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_reg      <= HDR;
            n_reg          <= 32'd0;
            word_idx_reg   <= 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_reg        <= 32'd0;
`endif
            pro_addr_reg   <= 32'd0;
            pro_data_reg   <= 32'd0;
            memwrite_reg   <= 1'b0;
            load_done_reg  <= 1'b0;
            load_error_reg <= 1'b0;
            tx_valid_reg   <= 1'b0;
            tx_data_reg    <= 8'd0;
        end else begin
            state_reg      <= state_next;
            n_reg          <= n_next;
            word_idx_reg   <= word_idx_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_reg        <= sum_next;
`endif
            pro_addr_reg   <= pro_addr_next;
            pro_data_reg   <= pro_data_next;
            memwrite_reg   <= memwrite_next;
            load_done_reg  <= load_done_next;
            load_error_reg <= load_error_next;
            tx_valid_reg   <= tx_valid_next;
            tx_data_reg    <= tx_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        word_idx_next = word_idx_reg;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_next      = sum_reg;
`endif
        case (state_reg)
            HDR: begin
                if (word_valid) begin
                    n_next        = word;
                    word_idx_next = 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_next      = 32'd0;
`endif
                    if (word == 32'd0) begin
                        state_next = POST_DATA;
                    end else if (word > MAX_WORDS) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid) begin
                    word_idx_next = word_idx_reg + 32'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_next      = sum_reg + word;
`endif
                    if (word_idx_reg == n_reg - 32'd1) begin
                        state_next = POST_DATA;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (word_valid) begin
                    state_next = (word == sum_reg) ? DONE : ERR;
                end
            end
`endif
            default: begin
                state_next = state_reg;
            end
        endcase
    end

    // Outputs are registered from these values, giving the one-cycle latency
    // from the completing byte to the write / acknowledge.
    always_comb begin
        memwrite_next   = (state_reg == DATA) && word_valid;
        pro_addr_next   = memwrite_next ? ((word_idx_reg + 32'd1) << 2) : pro_addr_reg;
        pro_data_next   = memwrite_next ? word : pro_data_reg;
        enter_done      = (state_next == DONE) && (state_reg != DONE);
        enter_err       = (state_next == ERR) && (state_reg != ERR);
        load_done_next  = load_done_reg | enter_done;
        load_error_next = load_error_reg | enter_err;
        tx_valid_next   = enter_done | enter_err;
        tx_data_next    = tx_data_reg;
        if (enter_done) begin
            tx_data_next = ACK_BYTE;
        end else if (enter_err) begin
            tx_data_next = NAK_BYTE;
        end
    end

    assign pro_addr   = pro_addr_reg;
    assign pro_data   = pro_data_reg;
    assign memwrite   = memwrite_reg;
    assign load_done  = load_done_reg;
    assign load_error = load_error_reg;
    assign tx_valid   = tx_valid_reg;
    assign tx_data    = tx_data_reg;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random images checked
// cycle by cycle against a byte-position model of the load protocol.
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [31:0] pro_addr;
    logic [31:0] pro_data;
    logic        memwrite;
    logic        load_done;
    logic        load_error;
    logic        tx_valid;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    program_loader dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .pro_addr   (pro_addr),
        .pro_data   (pro_data),
        .memwrite   (memwrite),
        .load_done  (load_done),
        .load_error (load_error),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // expected outputs for the next sample point
    logic        e_memwrite, e_done, e_err, e_tx_valid;
    logic [31:0] e_addr, e_data;
    logic [7:0]  e_tx_data;

    // reference model: image position and running totals
    logic [7:0]  m_bytes[$];
    int          m_words;
    logic [31:0] m_n;
    logic [31:0] m_sum;
    bit          m_term;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_outputs();
        check("memwrite",   32'(memwrite),   32'(e_memwrite));
        check("pro_addr",   pro_addr,        e_addr);
        check("pro_data",   pro_data,        e_data);
        check("load_done",  32'(load_done),  32'(e_done));
        check("load_error", 32'(load_error), 32'(e_err));
        check("tx_valid",   32'(tx_valid),   32'(e_tx_valid));
        check("tx_data",    32'(tx_data),    32'(e_tx_data));
        if (memwrite === 1'b1)
            $display("WR   addr=0x%08h data=0x%08h", pro_addr, pro_data);
        if (tx_valid === 1'b1)
            $display("TX   byte=0x%02h done=%0d error=%0d", tx_data, load_done, load_error);
    endtask

    task automatic model_reset();
        m_bytes.delete();
        m_words = 0; m_n = 0; m_sum = 0; m_term = 1'b0;
        e_memwrite = 0; e_done = 0; e_err = 0; e_tx_valid = 0;
        e_addr = 0; e_data = 0; e_tx_data = 0;
    endtask

    task automatic model_finish(input bit ok);
        m_term     = 1'b1;
        e_tx_valid = 1'b1;
        if (ok) begin
            e_done = 1'b1; e_tx_data = 8'hAA;
        end else begin
            e_err = 1'b1;  e_tx_data = 8'h55;
        end
    endtask

    // Word 0 is the header, words 1..N are data, word N+1 is the checksum.
    task automatic model_step(input logic v, input logic [7:0] b);
        logic [31:0] w;
        int          idx;
        e_memwrite = 1'b0;
        e_tx_valid = 1'b0;
        if (v && !m_term) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                w = 32'(m_bytes[0]) + 32'(m_bytes[1]) * 256 + 32'(m_bytes[2]) * 65536
                  + 32'(m_bytes[3]) * 16777216;
                m_bytes.delete();
                idx = m_words;
                m_words++;
                if (idx == 0) begin
                    m_n = w;
                    if (w == 0) begin
                        if (!CSUM_EN) model_finish(1'b1);
                    end else if (w > 32'd23001) begin
                        model_finish(1'b0);
                    end
                end else if (32'(idx) <= m_n) begin
                    e_memwrite = 1'b1;
                    e_addr     = 32'(idx) * 4;
                    e_data     = w;
                    m_sum      = m_sum + w;
                    if (32'(idx) == m_n && !CSUM_EN) model_finish(1'b1);
                end else begin
                    model_finish(w == m_sum);
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] b);
        @(negedge clk);
        check_outputs();
        rx_valid = v;
        rx_data  = b;
        model_step(v, b);
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, 8'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        rstn     = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        check_outputs();
        rstn = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(gap_max, 0)) cycle(1'b0, 8'($urandom));
            cycle(1'b1, w[8*j +: 8]);
        end
    endtask

    task automatic send_image(input logic [31:0] n, input logic [31:0] words[$],
                              input int gap_max, input bit bad_csum);
        logic [31:0] sum;
        $display("IMG  n=%0d gap_max=%0d bad_csum=%0d", n, gap_max, bad_csum);
        sum = 0;
        send_word(n, gap_max);
        foreach (words[k]) begin
            send_word(words[k], gap_max);
            sum = sum + words[k];
        end
        if (CSUM_EN) send_word(bad_csum ? sum + 32'd1 : sum, gap_max);
    endtask

    initial begin
        logic [31:0] q[$];
        int          n;

        do_reset();

        q = '{32'h11223344, 32'hDEADBEEF};
        send_image(32'd2, q, 0, 1'b0);
        idle(3);

        do_reset();
        q.delete();
        send_image(32'd0, q, 0, 1'b0);
        idle(3);

        do_reset();
        send_word(32'd23002, 0);
        repeat (8) cycle(1'b1, 8'($urandom));
        idle(2);

        do_reset();
        q = '{$urandom, $urandom, $urandom};
        send_image(32'd3, q, 0, 1'b0);
        idle(2);
        do_reset();
        send_image(32'd3, q, 5, 1'b0);
        idle(2);

        // reset in the middle of data word 1, then a fresh single-word image
        do_reset();
        send_word(32'd4, 0);
        send_word($urandom, 0);
        cycle(1'b1, 8'($urandom));
        cycle(1'b1, 8'($urandom));
        do_reset();
        q = '{$urandom};
        send_image(32'd1, q, 2, 1'b0);
        idle(3);

        // largest accepted count starts a load normally
        do_reset();
        send_word(32'd23001, 0);
        send_word($urandom, 1);
        send_word($urandom, 0);
        idle(2);

        if (CSUM_EN) begin
            do_reset();
            q = '{32'd1, 32'd2};
            send_image(32'd2, q, 0, 1'b0);
            idle(2);
            do_reset();
            send_image(32'd2, q, 0, 1'b1);
            idle(2);
        end

        for (int r = 0; r < 12; r++) begin
            do_reset();
            n = $urandom_range(6, 0);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back($urandom);
            send_image(32'(n), q, $urandom_range(3, 0), CSUM_EN && ($urandom_range(1, 0) == 1));
            repeat (3) cycle(1'b1, 8'($urandom));
            idle(2);
        end

        idle(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
